// File: rtl/cpu_divmod_ctrl.sv
// Sequencer that shares the divmod32/divmod64 units with the execute stage.
// Optional macro CPU_DIVMOD_ZERO_BYPASS_EN answers zero-denominator commands without the unit.
module cpu_divmod_ctrl #(
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wide,
    input  logic                 req_signed,
    input  logic [63:0]          req_num,
    input  logic [63:0]          req_denom,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 d32_enable,
    output logic                 d32_unsgn_or_sgn,
    output logic [31:0]          d32_num,
    output logic [31:0]          d32_denom,
    input  logic [31:0]          d32_quot,
    input  logic [31:0]          d32_rem,
    input  logic                 d32_can_accept_cmd,
    input  logic                 d32_data_ready,
    output logic                 d64_enable,
    output logic                 d64_unsgn_or_sgn,
    output logic [63:0]          d64_num,
    output logic [63:0]          d64_denom,
    input  logic [63:0]          d64_quot,
    input  logic [63:0]          d64_rem,
    input  logic                 d64_can_accept_cmd,
    input  logic                 d64_data_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_quot,
    output logic [63:0]          rsp_rem,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic                 rsp_div_by_zero,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                 state_q, state_d;
    logic                   wide_q, wide_d;
    logic                   sgn_q, sgn_d;
    logic [63:0]            num_q, num_d;
    logic [63:0]            denom_q, denom_d;
    logic [63:0]            quot_q, quot_d;
    logic [63:0]            rem_q, rem_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   unit_free, unit_done;

    assign unit_free = wide_q ? d64_can_accept_cmd : d32_can_accept_cmd;
    assign unit_done = wide_q ? d64_data_ready : d32_data_ready;

`ifdef CPU_DIVMOD_ZERO_BYPASS_EN
    logic dbz_q, dbz_d;
    logic denom_zero;
    assign denom_zero = req_wide ? (req_denom == 64'h0) : (req_denom[31:0] == 32'h0);
    assign rsp_div_by_zero = dbz_q;
`else
    assign rsp_div_by_zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wide_d  = wide_q;
        sgn_d   = sgn_q;
        num_d   = num_q;
        denom_d = denom_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
`ifdef CPU_DIVMOD_ZERO_BYPASS_EN
        dbz_d   = dbz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wide_d  = req_wide;
                    sgn_d   = req_signed;
                    num_d   = req_num;
                    denom_d = req_denom;
                    tag_d   = req_tag;
                    state_d = StIssue;
`ifdef CPU_DIVMOD_ZERO_BYPASS_EN
                    dbz_d   = 1'b0;
                    if (denom_zero) begin
                        quot_d  = req_wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
                        rem_d   = req_wide ? req_num : {32'h0, req_num[31:0]};
                        dbz_d   = 1'b1;
                        state_d = StResp;
                    end
`endif
                end
            end
            StIssue: begin
                if (unit_free) state_d = StWait;
            end
            StWait: begin
                // Narrow results are zero-extended, never sign-extended.
                if (unit_done) begin
                    quot_d  = wide_q ? d64_quot : {32'h0, d32_quot};
                    rem_d   = wide_q ? d64_rem : {32'h0, d32_rem};
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wide_q  <= 1'b0;
            sgn_q   <= 1'b0;
            num_q   <= 64'h0;
            denom_q <= 64'h0;
            quot_q  <= 64'h0;
            rem_q   <= 64'h0;
            tag_q   <= '0;
`ifdef CPU_DIVMOD_ZERO_BYPASS_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wide_q  <= wide_d;
            sgn_q   <= sgn_d;
            num_q   <= num_d;
            denom_q <= denom_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
`ifdef CPU_DIVMOD_ZERO_BYPASS_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    // Operands are presented only while issuing; the units latch them on enable.
    always_comb begin
        d32_enable       = 1'b0;
        d32_unsgn_or_sgn = 1'b0;
        d32_num          = 32'h0;
        d32_denom        = 32'h0;
        d64_enable       = 1'b0;
        d64_unsgn_or_sgn = 1'b0;
        d64_num          = 64'h0;
        d64_denom        = 64'h0;
        if (state_q == StIssue) begin
            if (wide_q) begin
                d64_enable       = d64_can_accept_cmd;
                d64_unsgn_or_sgn = sgn_q;
                d64_num          = num_q;
                d64_denom        = denom_q;
            end else begin
                d32_enable       = d32_can_accept_cmd;
                d32_unsgn_or_sgn = sgn_q;
                d32_num          = num_q[31:0];
                d32_denom        = denom_q[31:0];
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_quot  = quot_q;
    assign rsp_rem   = rem_q;
    assign rsp_tag   = tag_q;

endmodule

// File: tb/tb_cpu_divmod_ctrl.sv
// Randomized bench for cpu_divmod_ctrl: the bench plays both divide units and predicts
// each response from the request with plain arithmetic.
module tb_cpu_divmod_ctrl;

    localparam int unsigned TW = 5;
`ifdef CPU_DIVMOD_ZERO_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_wide = 1'b0, req_signed = 1'b0;
    logic [63:0]   req_num = '0, req_denom = '0;
    logic [TW-1:0] req_tag = '0;
    logic          d32_enable, d32_unsgn_or_sgn;
    logic [31:0]   d32_num, d32_denom;
    logic [31:0]   d32_quot = '0, d32_rem = '0;
    logic          d32_can_accept_cmd = 1'b0, d32_data_ready = 1'b0;
    logic          d64_enable, d64_unsgn_or_sgn;
    logic [63:0]   d64_num, d64_denom;
    logic [63:0]   d64_quot = '0, d64_rem = '0;
    logic          d64_can_accept_cmd = 1'b0, d64_data_ready = 1'b0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [63:0]   rsp_quot, rsp_rem;
    logic [TW-1:0] rsp_tag;
    logic          rsp_div_by_zero, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int en32_cnt = 0;
    int en64_cnt = 0;

    cpu_divmod_ctrl #(.TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wide(req_wide),
        .req_signed(req_signed), .req_num(req_num), .req_denom(req_denom), .req_tag(req_tag),
        .d32_enable(d32_enable), .d32_unsgn_or_sgn(d32_unsgn_or_sgn),
        .d32_num(d32_num), .d32_denom(d32_denom), .d32_quot(d32_quot), .d32_rem(d32_rem),
        .d32_can_accept_cmd(d32_can_accept_cmd), .d32_data_ready(d32_data_ready),
        .d64_enable(d64_enable), .d64_unsgn_or_sgn(d64_unsgn_or_sgn),
        .d64_num(d64_num), .d64_denom(d64_denom), .d64_quot(d64_quot), .d64_rem(d64_rem),
        .d64_can_accept_cmd(d64_can_accept_cmd), .d64_data_ready(d64_data_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
        .rsp_tag(rsp_tag), .rsp_div_by_zero(rsp_div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (d32_enable) en32_cnt++;
        if (d64_enable) en64_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Divide semantics: zero denominator yields all-ones quotient and the numerator as remainder.
    function automatic void div_ref(input logic w, input logic s, input logic [63:0] n,
                                    input logic [63:0] d, output logic [63:0] q,
                                    output logic [63:0] r);
        logic [31:0] n32, d32, q32, r32;
        n32 = n[31:0];
        d32 = d[31:0];
        if (w) begin
            if (d == 64'h0) begin q = '1; r = n; end
            else if (s) begin q = $signed(n) / $signed(d); r = $signed(n) % $signed(d); end
            else begin q = n / d; r = n % d; end
        end else begin
            if (d32 == 32'h0) begin q32 = '1; r32 = n32; end
            else if (s) begin q32 = $signed(n32) / $signed(d32); r32 = $signed(n32) % $signed(d32); end
            else begin q32 = n32 / d32; r32 = n32 % d32; end
            q = {32'h0, q32};
            r = {32'h0, r32};
        end
    endfunction

    task automatic set_can(input logic w, input logic v);
        if (w) begin d64_can_accept_cmd = v; d32_can_accept_cmd = 1'($urandom); end
        else   begin d32_can_accept_cmd = v; d64_can_accept_cmd = 1'($urandom); end
    endtask

    task automatic run_cmd(input logic w, input logic s, input logic [63:0] n,
                           input logic [63:0] d, input logic [TW-1:0] t,
                           input int busy_cyc, input int k, input int bp);
        logic [63:0] eq, er, uq, ur, un, ud;
        logic        zero, byp, us;
        int          b32, b64;
        div_ref(w, s, n, d, eq, er);
        zero = w ? (d == 64'h0) : (d[31:0] == 32'h0);
        byp  = Bypass && zero;
        b32  = en32_cnt;
        b64  = en64_cnt;
        req_valid = 1'b1; req_wide = w; req_signed = s;
        req_num = n; req_denom = d; req_tag = t;
        set_can(w, 1'b0);
        #1 check_eq("accept_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_num = {$urandom, $urandom}; req_denom = {$urandom, $urandom}; req_tag = TW'($urandom);
        if (!byp) begin
            for (int i = 0; i < busy_cyc; i++) begin
                #1 check_eq("issue_hold_en", 64'(w ? d64_enable : d32_enable), 64'd0);
                check_eq("issue_busy", 64'(busy), 64'd1);
                @(negedge clk);
                set_can(w, 1'b0);
            end
            set_can(w, 1'b1);
            // A data_ready coinciding with the enable pulse must be ignored.
            if (w) begin d64_data_ready = 1'b1; d64_quot = {$urandom, $urandom}; end
            else begin d32_data_ready = 1'b1; d32_quot = $urandom; end
            #1;
            if (w) begin
                check_eq("en64", 64'(d64_enable), 64'd1);
                check_eq("en32_off", 64'(d32_enable), 64'd0);
                check_eq("op64_num", d64_num, n);
                check_eq("op64_den", d64_denom, d);
                check_eq("op64_sgn", 64'(d64_unsgn_or_sgn), 64'(s));
                check_eq("op32_idle", 64'(d32_num), 64'd0);
                un = d64_num; ud = d64_denom; us = d64_unsgn_or_sgn;
            end else begin
                check_eq("en32", 64'(d32_enable), 64'd1);
                check_eq("en64_off", 64'(d64_enable), 64'd0);
                check_eq("op32_num", 64'(d32_num), {32'h0, n[31:0]});
                check_eq("op32_den", 64'(d32_denom), {32'h0, d[31:0]});
                check_eq("op32_sgn", 64'(d32_unsgn_or_sgn), 64'(s));
                check_eq("op64_idle", d64_num, 64'd0);
                un = {32'h0, d32_num}; ud = {32'h0, d32_denom}; us = d32_unsgn_or_sgn;
            end
            div_ref(w, us, un, ud, uq, ur);
            @(negedge clk);
            for (int i = 1; i < k; i++) begin
                set_can(w, 1'($urandom));
                if (w) begin
                    d64_data_ready = 1'b0;
                    d32_data_ready = 1'($urandom); d32_quot = $urandom; d32_rem = $urandom;
                end else begin
                    d32_data_ready = 1'b0;
                    d64_data_ready = 1'($urandom);
                    d64_quot = {$urandom, $urandom}; d64_rem = {$urandom, $urandom};
                end
                #1 check_eq("wait_no_rsp", 64'(rsp_valid), 64'd0);
                check_eq("wait_no_en", 64'(w ? d64_enable : d32_enable), 64'd0);
                @(negedge clk);
            end
            if (w) begin
                d64_data_ready = 1'b1; d64_quot = uq; d64_rem = ur;
                d32_data_ready = 1'($urandom); d32_quot = $urandom; d32_rem = $urandom;
            end else begin
                d32_data_ready = 1'b1; d32_quot = uq[31:0]; d32_rem = ur[31:0];
                d64_data_ready = 1'($urandom);
                d64_quot = {$urandom, $urandom}; d64_rem = {$urandom, $urandom};
            end
            #1 check_eq("capture_no_rsp", 64'(rsp_valid), 64'd0);
            @(negedge clk);
            d32_data_ready = 1'b0; d64_data_ready = 1'b0;
            d32_quot = $urandom; d64_quot = {$urandom, $urandom};
            d32_rem = $urandom; d64_rem = {$urandom, $urandom};
        end
        for (int j = 0; j <= bp; j++) begin
            rsp_ready = (j == bp);
            req_valid = (j != bp);
            #1 check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
            check_eq("rsp_quot", rsp_quot, eq);
            check_eq("rsp_rem", rsp_rem, er);
            check_eq("rsp_tag", 64'(rsp_tag), 64'(t));
            check_eq("rsp_dbz", 64'(rsp_div_by_zero), 64'(byp));
            check_eq("rsp_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        #1 check_eq("after_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("after_rsp_ready", 64'(req_ready), 64'd1);
        check_eq("after_rsp_busy", 64'(busy), 64'd0);
        check_eq("en32_count", 64'(en32_cnt - b32), 64'((!byp && !w) ? 1 : 0));
        check_eq("en64_count", 64'(en64_cnt - b64), 64'((!byp && w) ? 1 : 0));
    endtask

    initial begin
        logic [63:0] rn, rd;
        int b32;
        repeat (2) @(negedge clk);
        #1 check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_dbz", 64'(rsp_div_by_zero), 64'd0);
        check_eq("rst_en", 64'({d32_enable, d64_enable}), 64'd0);
        check_eq("rst_quot", rsp_quot, 64'd0);
        check_eq("rst_rem", rsp_rem, 64'd0);
        check_eq("rst_tag", 64'(rsp_tag), 64'd0);
        check_eq("rst_ops", d64_num | d64_denom | {32'h0, d32_num | d32_denom}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(1'b0, 1'b0, 64'd100, 64'd7, 5'd3, 0, 3, 0);
        run_cmd(1'b1, 1'b1, -64'sd100, 64'd7, 5'd17, 4, 2, 0);
        run_cmd(1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'h0000_0001_0000_0003, 5'd9, 0, 1, 6);
        run_cmd(1'b0, 1'b0, 64'h1234, 64'h0, 5'd21, 0, 2, 1);
        run_cmd(1'b1, 1'b1, 64'h55, 64'h0, 5'd2, 1, 1, 0);

        // Reset while waiting on d32, then a stale data_ready arrives.
        b32 = en32_cnt;
        req_valid = 1'b1; req_wide = 1'b0; req_signed = 1'b0;
        req_num = 64'd50; req_denom = 64'd5; req_tag = 5'd4;
        d32_can_accept_cmd = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_eq("rstw_busy", 64'(busy), 64'd0);
        check_eq("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rstw_ready", 64'(req_ready), 64'd1);
        check_eq("rstw_en", 64'(d32_enable), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d32_data_ready = 1'b1; d32_quot = 32'hAAAA_5555; d32_rem = 32'h1;
        @(negedge clk);
        d32_data_ready = 1'b0;
        #1 check_eq("stale_busy", 64'(busy), 64'd0);
        check_eq("stale_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("stale_en_count", 64'(en32_cnt - b32), 64'd1);
        run_cmd(1'b0, 1'b1, 64'hFFFF_FFF0, 64'h3, 5'd30, 2, 1, 0);

        for (int it = 0; it < 30; it++) begin
            rn = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            if (($urandom % 4) == 0) rd = rd >> ($urandom % 64);
            if (($urandom % 8) == 0) rd = '0;
            run_cmd(1'($urandom), 1'($urandom), rn, rd, TW'($urandom),
                    int'($urandom % 4), int'(1 + $urandom % 4), int'($urandom % 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_divmod_ctrl.md
# cpu_divmod_ctrl

Sequencer that shares the CPU's 32-bit and 64-bit integer divide units (divmod32, divmod64) with the execute stage. It accepts one divide command at a time, waits for the selected unit to be free, and issues a single-cycle enable. It captures the quotient and remainder when the unit signals completion and holds them until the writeback side accepts. It also drives a busy/stall indication, so the execute stage can stay in its multi-cycle divide state without tracking unit handshakes itself.

## Interface
Parameters:
- TAG_WIDTH, 5: width of the opaque destination tag carried from request to response (GPR index).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  controller can accept a command.
- req_wide  in  1  0 = divmod32, 1 = divmod64.
- req_signed  in  1  0 = unsigned, 1 = signed (drives unsgn_or_sgn).
- req_num, req_denom  in  64 each  operands; bits 63:32 ignored when req_wide=0.
- req_tag  in  TAG_WIDTH  returned unchanged on rsp_tag.
- d32_enable  out  1; d32_unsgn_or_sgn  out  1; d32_num, d32_denom  out  32 each.
- d32_quot, d32_rem  in  32 each; d32_can_accept_cmd, d32_data_ready  in  1 each.
- d64_enable  out  1; d64_unsgn_or_sgn  out  1; d64_num, d64_denom  out  64 each.
- d64_quot, d64_rem  in  64 each; d64_can_accept_cmd, d64_data_ready  in  1 each.
- rsp_valid  out  1; rsp_ready  in  1.
- rsp_quot, rsp_rem  out  64 each; rsp_tag  out  TAG_WIDTH; rsp_div_by_zero  out  1.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid&&req_ready, register wide, signed, num, denom and tag, then go to ISSUE.
- ISSUE: operand outputs of the selected unit show the registered values.
  - When the selected unit's can_accept_cmd=1, assert its enable for exactly one cycle and go to WAIT.
  - If can_accept_cmd=0, stay in ISSUE indefinitely with enable low.
- WAIT: sample only the selected unit's data_ready.
  - When it is 1, capture quot/rem into the response registers and go to RESP.
  - The other unit's data_ready is ignored.
- RESP: rsp_valid=1; outputs stay stable until rsp_ready=1, then go to IDLE.
  - No new request is accepted in RESP; req_ready=0.
- Width rule: narrow results are zero-extended to 64 bits on rsp_quot/rsp_rem. Signed narrow results are not sign-extended; the consumer writes only 32 bits.
- Unselected unit: enable=0, operand outputs 0.
- Signed overflow (most-negative / -1) is passed to the unit; its result is returned verbatim.

## Timing
- Reset values: state=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_div_by_zero=0. All enables, operand and response data outputs are 0; rsp_tag=0.
- Minimum latency (unit free, unit returns data_ready in cycle k after the enable):
  - cycle 0: request accepted.
  - cycle 1: enable pulse.
  - cycle 1+k: capture.
  - cycle 2+k: rsp_valid.
- data_ready in the same cycle as the enable pulse is ignored; sampling starts the cycle after.
- Reset asserted mid-operation: immediate return to IDLE and enables drop.
  - A late data_ready from an abandoned command arriving in IDLE is ignored.
  - The next issue still waits on can_accept_cmd.
- rsp_ready held high in RESP: RESP lasts one cycle; IDLE follows, with req_ready=1 the next cycle.

## Configuration
- CPU_DIVMOD_ZERO_BYPASS_EN defined: the zero check runs at request acceptance, on the low 32 bits of req_denom when narrow and all 64 bits when wide.
  - A zero denominator skips ISSUE/WAIT and goes directly to RESP in cycle 1.
  - Response: rsp_quot = all ones at the operand width (zero-extended when narrow), rsp_rem = num, rsp_div_by_zero=1.
  - The unit is never enabled.
- Not defined: a zero denominator is issued to the unit like any other command, and rsp_div_by_zero is tied 0.

## Test plan
- Narrow unsigned: num=100, denom=7, d32 free, data_ready 3 cycles after the enable -> one d32_enable pulse; rsp_quot=14, rsp_rem=2, rsp_valid in cycle 5.
- Wide signed: num=-100, denom=7, d64_can_accept_cmd low for 4 cycles -> d64_enable fires on the first cycle it is high; unit outputs returned verbatim, correct rsp_tag.
- Backpressure: rsp_ready low for 6 cycles -> rsp_* stable, req_ready=0, and a req_valid pulse is not accepted.
- With bypass: narrow denom=0, num=0x1234 -> rsp_valid in cycle 1, rsp_quot=0x00000000FFFFFFFF, rsp_rem=0x1234, div_by_zero=1, no enable. Without bypass: same stimulus is issued to d32 and div_by_zero=0.
- Reset in WAIT, then d32_data_ready pulses -> state IDLE, rsp_valid stays 0, busy=0, next command completes normally.
